// File: rtl/pokey_pcm_decimator.sv
// pokey_pcm_decimator
//   Turns the 1-bit POKEY aud PWM stream into signed PCM samples. Ones are
//   counted over a fixed DECIM-cycle window (boxcar decimation). Each count is
//   scaled to OUT_W bits and recentred to two's complement. Results are queued
//   in a small FIFO with a valid/ready head.
//
// Ports
//   clk           system clock, shared with POKEY
//   clr           asynchronous active-high reset; release is taken on clk
//   pwm_in        POKEY aud bit, sampled every clk
//   en            decimation enable; low discards the partial window
//   sample_data   head-of-queue PCM sample (signed), 0 when the queue is empty
//   sample_valid  sample_data holds a queued sample
//   sample_ready  consumer takes the head sample this cycle
//   fifo_level    number of queued samples, 0..FIFO_DEPTH
//   overflow      sticky: a finished sample was dropped because the queue was full

module pokey_pcm_decimator #(
    parameter int DECIM      = 2083,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          pwm_in,
    input  logic                          en,
    output logic [OUT_W-1:0]              sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int RAW_W  = $clog2(DECIM + 1);
    localparam int CNT_W  = $clog2(DECIM);
    localparam int GAIN_W = OUT_W + 9;
    localparam int PROD_W = RAW_W + GAIN_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    localparam longint unsigned GAIN   = (longint'(1) << (OUT_W + 8)) / longint'(DECIM);
    localparam logic [GAIN_W-1:0] GAIN_V = GAIN_W'(GAIN);

    // ------------------------------------------------------------------
    // Window accumulation
    // ------------------------------------------------------------------
    // armed goes high on the first edge after clr is released, so that edge
    // does not count toward the first window.
    logic             armed;
    logic [CNT_W-1:0] win_cnt;
    logic [RAW_W-1:0] acc;
    logic [RAW_W-1:0] raw;
    logic             raw_vld;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            armed   <= 1'b0;
            win_cnt <= '0;
            acc     <= '0;
            raw     <= '0;
            raw_vld <= 1'b0;
        end else begin
            armed   <= 1'b1;
            raw_vld <= 1'b0;
            if (armed && en) begin
                if (win_cnt == CNT_W'(DECIM - 1)) begin
                    raw     <= acc + RAW_W'(pwm_in);
                    raw_vld <= 1'b1;
                    win_cnt <= '0;
                    acc     <= '0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    acc     <= acc + RAW_W'(pwm_in);
                end
            end else begin
                win_cnt <= '0;
                acc     <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scaling: u = min((raw * GAIN) >> 8, 2^OUT_W - 1)
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] scaled;
    logic [OUT_W-1:0]  u_next;
    logic [OUT_W-1:0]  u;
    logic              u_vld;

    always_comb begin
        prod   = PROD_W'(raw) * PROD_W'(GAIN_V);
        scaled = prod >> 8;
        if (scaled > PROD_W'({OUT_W{1'b1}})) begin
            u_next = '1;
        end else begin
            u_next = scaled[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            u     <= '0;
            u_vld <= 1'b0;
        end else begin
            u_vld <= raw_vld;
            if (raw_vld) begin
                u <= u_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output queue. The write itself is the offset-binary to two's
    // complement stage: the MSB of u is inverted on the way in.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OUT_W-1:0] push_data;
    logic             pop;
    logic             full;
    logic             accept;

    always_comb begin
        push_data = {~u[OUT_W-1], u[OUT_W-2:0]};
        pop       = sample_valid && sample_ready;
        full      = (fifo_level == LVL_W'(FIFO_DEPTH));
        accept    = u_vld && (!full || pop);
    end

    // Storage carries no reset; entries are only visible through fifo_level.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (u_vld && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        sample_valid = (fifo_level != '0);
        sample_data  = '0;
        if (sample_valid) begin
            sample_data = mem[rd_ptr];
        end
    end

endmodule
